// File: rtl/pomiar_obrotow_pkg.sv
// pomiar_obrotow_pkg: rpm width, saturation limit and counter helper shared with the BCD stage
package pomiar_obrotow_pkg;
    localparam int RPM_W   = 7;
    localparam int RPM_MAX = 99;
    typedef logic [RPM_W-1:0] rpm_t;
    // Holding at RPM_MAX+1 keeps the overflow visible without ever wrapping
    function automatic rpm_t sat_inc(input rpm_t c);
        return (c == rpm_t'(RPM_MAX + 1)) ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/pomiar_obrotow_filtr_wejscia.sv
// filtr_wejscia: 2-FF synchroniser, run-length glitch filter and registered rising-edge pulse
module filtr_wejscia #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0]    sync;
    logic [CW-1:0] run;
    logic          differ;
    logic          flip;
    assign differ = sync[1] != level;
    assign flip   = differ && (run == CW'(FILTER_LEN - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            run   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync  <= {sync[0], in};
            run   <= (differ && !flip) ? run + 1'b1 : '0;
            level <= flip ? sync[1] : level;
            rise  <= flip && sync[1];
        end
    end
endmodule

// File: rtl/pomiar_obrotow.sv
// pomiar_obrotow: counts filtered sensor edges per gate window and latches the saturated count
module pomiar_obrotow
    import pomiar_obrotow_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             czujnik,
    output logic [RPM_W-1:0] rpm,
    output logic             rpm_valid,
    output logic             przekroczenie
);
    localparam int GW = $clog2(GATE_CYCLES);
    logic [GW-1:0] gate;
    rpm_t          cnt;
    rpm_t          cnt_next;
    logic          level;
    logic          rise;
    logic          last;
    filtr_wejscia #(.FILTER_LEN(FILTER_LEN)) u_filtr (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (czujnik),
        .level (level),
        .rise  (rise)
    );
    assert property (@(posedge clk) disable iff (!rst_n) rise |-> level);
    assign last     = en && (gate == GW'(GATE_CYCLES - 1));
    // An edge in the closing cycle still belongs to the window being latched
    assign cnt_next = (en && rise) ? sat_inc(cnt) : cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate          <= '0;
            cnt           <= '0;
            rpm           <= '0;
            rpm_valid     <= 1'b0;
            przekroczenie <= 1'b0;
        end else begin
            rpm_valid <= last;
            gate      <= en ? (last ? '0 : gate + 1'b1) : gate;
            cnt       <= last ? '0 : cnt_next;
            if (last) begin
                rpm           <= (cnt_next > rpm_t'(RPM_MAX)) ? rpm_t'(RPM_MAX) : cnt_next;
                przekroczenie <= cnt_next > rpm_t'(RPM_MAX);
            end
        end
    end
endmodule

// File: tb/tb_pomiar_obrotow.sv
// tb_pomiar_obrotow: directed window vectors plus enable-gating and mid-window reset sequences
module tb_pomiar_obrotow;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       czujnik = 1'b0;
    logic [6:0] rpm;
    logic       rpm_valid;
    logic       przekroczenie;
    int         cycle = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    typedef struct {
        int n_glitch;
        int n_pulse;
        int hi;
        int lo;
        int exp_rpm;
        int exp_prz;
        int exp_period;
    } vec_t;
    vec_t vecs[9];

    pomiar_obrotow #(.GATE_CYCLES(1000), .FILTER_LEN(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .czujnik       (czujnik),
        .rpm           (rpm),
        .rpm_valid     (rpm_valid),
        .przekroczenie (przekroczenie)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        czujnik = 1'b1;
        repeat (hi) @(negedge clk);
        czujnik = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, output int when);
        when = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rpm_valid) begin
                when = cycle;
                return;
            end
        end
    endtask

    initial begin
        int t_prev;
        int t_now;
        int t_rel;
        vecs[0] = '{0, 22, 20, 20, 22, 0, 1000};
        vecs[1] = '{0, 95, 5, 5, 95, 0, 1000};
        vecs[2] = '{0, 150, 3, 3, 99, 1, 1000};
        vecs[3] = '{0, 10, 20, 20, 10, 0, 1000};
        vecs[4] = '{30, 5, 20, 20, 5, 0, 1000};
        vecs[5] = '{0, 1, 3, 20, 1, 0, 1000};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 1000};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 1000};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 1000};

        repeat (3) @(negedge clk);
        check("reset_rpm", int'(rpm), 0);
        check("reset_valid", int'(rpm_valid), 0);
        check("reset_prz", int'(przekroczenie), 0);
        rst_n = 1'b1;
        t_rel = cycle;
        wait_valid(1100, t_now);
        check("first_strobe_delay", t_now - t_rel, 1000);
        check("first_rpm_zero", int'(rpm), 0);
        t_prev = t_now;
        @(negedge clk);
        check("strobe_one_cycle", int'(rpm_valid), 0);

        foreach (vecs[k]) begin
            for (int g = 0; g < vecs[k].n_glitch; g++) pulse(2, 4);
            for (int p = 0; p < vecs[k].n_pulse; p++) pulse(vecs[k].hi, vecs[k].lo);
            wait_valid(1100, t_now);
            check($sformatf("v%0d_period", k), t_now - t_prev, vecs[k].exp_period);
            check($sformatf("v%0d_rpm", k), int'(rpm), vecs[k].exp_rpm);
            check($sformatf("v%0d_prz", k), int'(przekroczenie), vecs[k].exp_prz);
            t_prev = t_now;
            @(negedge clk);
            check($sformatf("v%0d_one_cycle", k), int'(rpm_valid), 0);
        end

        // 5 counted pulses, 400 frozen cycles with 30 ignored pulses, 3 more counted
        for (int p = 0; p < 5; p++) pulse(20, 20);
        en = 1'b0;
        for (int p = 0; p < 30; p++) pulse(6, 7);
        repeat (10) @(negedge clk);
        en = 1'b1;
        for (int p = 0; p < 3; p++) pulse(20, 20);
        wait_valid(1600, t_now);
        check("en_period", t_now - t_prev, 1400);
        check("en_rpm", int'(rpm), 8);
        check("en_prz", int'(przekroczenie), 0);
        t_prev = t_now;

        // Reset at gate count 500 after a partial count of 5
        @(negedge clk);
        for (int p = 0; p < 5; p++) pulse(20, 20);
        repeat (299) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_rpm_async", int'(rpm), 0);
        check("rst_prz_async", int'(przekroczenie), 0);
        check("rst_valid_async", int'(rpm_valid), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_strobe", int'(rpm_valid), 0);
        end
        rst_n = 1'b1;
        t_rel = cycle;
        for (int p = 0; p < 4; p++) pulse(20, 20);
        wait_valid(1100, t_now);
        check("rst_strobe_delay", t_now - t_rel, 1000);
        check("rst_rpm_fresh", int'(rpm), 4);
        check("rst_prz_fresh", int'(przekroczenie), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
